// File: rtl/crank_wheel_gen_pkg.sv
// Shared types and constants for the crank trigger-wheel generator.
package crank_wheel_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_GAP
  } state_t;

  localparam int MIN_PERIOD = 4;

endpackage

// File: rtl/crank_gen_slot_timer.sv
// Slot phase counter. It latches the clamped period at slot start and
// flags the half point and the last cycle of the slot.
module crank_gen_slot_timer
  import crank_wheel_gen_pkg::*;
#(
  parameter int PCNT_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  run,
  input  logic [PCNT_WIDTH-1:0] period_sh,
  output logic [PCNT_WIDTH-1:0] pcnt,
  output logic                  clamped,
  output logic                  half_end,
  output logic                  slot_end
);

  localparam logic [PCNT_WIDTH-1:0] MIN_P = PCNT_WIDTH'(MIN_PERIOD);
  localparam logic [PCNT_WIDTH-1:0] ONE   = PCNT_WIDTH'(1);

  logic [PCNT_WIDTH-1:0] period_act;
  logic [PCNT_WIDTH-1:0] eff_period;
  logic [PCNT_WIDTH-1:0] half;
  logic                  clamp_now;

  assign clamp_now  = period_sh < MIN_P;
  assign eff_period = clamp_now ? MIN_P : period_sh;
  assign half       = period_act >> 1;
  assign half_end   = (pcnt == half - ONE);
  assign slot_end   = (pcnt == period_act - ONE);

  // period_act only changes at slot start, so a new shadow never bends the current slot
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt       <= '0;
      period_act <= '0;
      clamped    <= 1'b0;
    end else if (start || (run && slot_end)) begin
      pcnt       <= '0;
      period_act <= eff_period;
      clamped    <= clamp_now;
    end else if (run) begin
      pcnt       <= pcnt + ONE;
    end else begin
      pcnt       <= '0;
      period_act <= '0;
      clamped    <= 1'b0;
    end
  end

endmodule

// File: rtl/crank_wheel_gen.sv
// Synthetic TEETH-minus-MISSING crank wheel generator with tooth index, gap and
// revolution outputs. Define CRANK_WHEEL_GEN_CAM_EN to add a once-per-two-revs cam_out.
module crank_wheel_gen
  import crank_wheel_gen_pkg::*;
#(
  parameter int PCNT_WIDTH = 24,
  parameter int TEETH      = 60,
  parameter int MISSING    = 2,
  parameter int TCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [PCNT_WIDTH-1:0] period_in,
  input  logic                  period_load,
  output logic                  tooth_out,
  output logic                  gap_out,
  output logic [TCNT_WIDTH-1:0] tcnt_out,
  output logic                  rev_pulse,
  output logic                  period_err
`ifdef CRANK_WHEEL_GEN_CAM_EN
  ,
  output logic                  cam_out
`endif
);

  localparam logic [TCNT_WIDTH-1:0] LAST_SLOT = TCNT_WIDTH'(TEETH - 1);
  localparam logic [TCNT_WIDTH-1:0] PRESENT   = TCNT_WIDTH'(TEETH - MISSING);

  state_t                state;
  logic [TCNT_WIDTH-1:0] tcnt;
  logic [TCNT_WIDTH-1:0] tcnt_nxt;
  logic [PCNT_WIDTH-1:0] period_sh;
  logic [PCNT_WIDTH-1:0] pcnt;
  logic                  clamped;
  logic                  half_end;
  logic                  slot_end;
  logic                  start;
  logic                  run;

  assign start    = (state == ST_IDLE) && ena;
  assign run      = (state != ST_IDLE) && ena;
  assign tcnt_nxt = (tcnt == LAST_SLOT) ? '0 : tcnt + TCNT_WIDTH'(1);

  crank_gen_slot_timer #(
    .PCNT_WIDTH(PCNT_WIDTH)
  ) u_slot_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .run      (run),
    .period_sh(period_sh),
    .pcnt     (pcnt),
    .clamped  (clamped),
    .half_end (half_end),
    .slot_end (slot_end)
  );

  // Outputs are registered from the pre-edge state, so they trail the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tcnt       <= '0;
      period_sh  <= '0;
      tooth_out  <= 1'b0;
      gap_out    <= 1'b0;
      tcnt_out   <= '0;
      rev_pulse  <= 1'b0;
      period_err <= 1'b0;
    end else begin
      if (period_load) period_sh <= period_in;

      tooth_out  <= (state == ST_HIGH);
      gap_out    <= (state == ST_GAP);
      tcnt_out   <= (state == ST_IDLE) ? '0 : tcnt;
      rev_pulse  <= (state != ST_IDLE) && (tcnt == '0) && (pcnt == '0);
      period_err <= (state != ST_IDLE) && clamped;

      case (state)
        ST_IDLE: begin
          tcnt <= '0;
          if (ena) state <= ST_HIGH;
        end
        default: begin
          if (!ena) begin
            state <= ST_IDLE;
            tcnt  <= '0;
          end else if (slot_end) begin
            tcnt  <= tcnt_nxt;
            state <= (tcnt_nxt < PRESENT) ? ST_HIGH : ST_GAP;
          end else if ((state == ST_HIGH) && half_end) begin
            state <= ST_LOW;
          end
        end
      endcase
    end
  end

`ifdef CRANK_WHEEL_GEN_CAM_EN
  logic rev_par;

  // rev_par is 0 during the first revolution after a start, so cam fires on even revolutions
  always_ff @(posedge clk) begin
    if (rst) begin
      rev_par <= 1'b0;
      cam_out <= 1'b0;
    end else begin
      cam_out <= (state != ST_IDLE) && (tcnt == '0) && !rev_par;
      if ((state == ST_IDLE) || !ena)
        rev_par <= 1'b0;
      else if (slot_end && (tcnt == LAST_SLOT))
        rev_par <= ~rev_par;
    end
  end
`endif

endmodule
